// File: rtl/edf_ic_pkg.sv
// Shared types and constants for the EDF interrupt sequencer and its nesting stack.
package edf_ic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        SETTLE = 2'd2
    } seq_state_e;

    localparam int unsigned SeqIdWidth = 2;
    localparam int unsigned SeqTsWidth = 64;

    typedef struct packed {
        logic [SeqIdWidth-1:0] id;
        logic [SeqTsWidth-1:0] dl;
    } nest_entry_t;

    localparam logic [SeqTsWidth-1:0] DlNone = {SeqTsWidth{1'b1}};

endpackage

// File: rtl/edf_nest_stack.sv
// LIFO of claimed interrupt entries; a simultaneous push and pop replaces the top entry.
module edf_nest_stack #(
    parameter int unsigned DataWidth = 66,
    parameter int unsigned Depth     = 4,
    localparam int unsigned LvlWidth = $clog2(Depth + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] top,
    output logic [LvlWidth-1:0]  depth,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DataWidth-1:0] mem_r [Depth];
    logic [LvlWidth-1:0]  cnt_r;
    logic [PtrWidth-1:0]  top_idx_s;
    logic [PtrWidth-1:0]  wr_idx_s;
    logic                 do_pop_s;
    logic                 do_push_s;

    assign empty     = (cnt_r == {LvlWidth{1'b0}});
    assign full      = (cnt_r == LvlWidth'(Depth));
    assign depth     = cnt_r;
    assign top_idx_s = PtrWidth'(cnt_r - LvlWidth'(1));
    assign wr_idx_s  = PtrWidth'(cnt_r);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign top       = empty ? {DataWidth{1'b0}} : mem_r[top_idx_s];

    // Entry storage and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {LvlWidth{1'b0}};
            for (int i = 0; i < int'(Depth); i++) begin
                mem_r[i] <= {DataWidth{1'b0}};
            end
        end else if (do_push_s && do_pop_s) begin
            mem_r[top_idx_s] <= wdata;
        end else if (do_push_s) begin
            mem_r[wr_idx_s] <= wdata;
            cnt_r           <= cnt_r + LvlWidth'(1);
        end else if (do_pop_s) begin
            cnt_r <= cnt_r - LvlWidth'(1);
        end
    end

endmodule

// File: rtl/edf_irq_sequencer.sv
// Offer/claim/complete sequencer with nested-preemption tracking for the EDF interrupt path.
// Optional deadline-miss detection is built when EDF_SEQ_DL_MISS_EN is defined.
module edf_irq_sequencer
    import edf_ic_pkg::*;
#(
    parameter int unsigned NrIrqs    = 4,
    parameter int unsigned TsWidth   = 64,
    parameter int unsigned NestDepth = 4,
    localparam int unsigned IdWidth  = (NrIrqs > 1) ? $clog2(NrIrqs) : 1,
    localparam int unsigned LvlWidth = $clog2(NestDepth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                arb_valid_i,
    input  logic [IdWidth-1:0]  arb_id_i,
    input  logic [TsWidth-1:0]  arb_dl_i,
    output logic                irq_valid_o,
    output logic [IdWidth-1:0]  irq_id_o,
    input  logic                irq_ready_i,
    input  logic                complete_i,
    input  logic [IdWidth-1:0]  complete_id_i,
    output logic [NrIrqs-1:0]   claim_o,
    output logic [TsWidth-1:0]  active_dl_o,
    output logic [LvlWidth-1:0] level_o,
    output logic                err_o,
    input  logic [63:0]         mtime_i,
    output logic                miss_o,
    input  logic                miss_clr_i
);

    seq_state_e          state_r, next_state_s;
    logic [IdWidth-1:0]  offer_id_r;
    logic [TsWidth-1:0]  offer_dl_r;
    logic                irq_valid_r;
    logic [NrIrqs-1:0]   claim_r;
    logic                err_r;
    logic                load_offer_s;
    logic                push_s;
    logic                offer_ok_s;
    logic                complete_ok_s;
    nest_entry_t         push_entry_s;
    nest_entry_t         top_entry_s;
    logic                full_s;
    logic                empty_s;
    logic [LvlWidth-1:0] depth_s;
    logic [TsWidth-1:0]  active_dl_s;

    assign push_entry_s.id = SeqIdWidth'(offer_id_r);
    assign push_entry_s.dl = SeqTsWidth'(offer_dl_r);

    edf_nest_stack #(
        .DataWidth ($bits(nest_entry_t)),
        .Depth     (NestDepth)
    ) u_stack (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_s),
        .pop   (complete_ok_s),
        .wdata (push_entry_s),
        .top   (top_entry_s),
        .depth (depth_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign active_dl_s   = empty_s ? {TsWidth{1'b1}} : TsWidth'(top_entry_s.dl);
    assign offer_ok_s    = arb_valid_i & ~full_s & (arb_dl_i < active_dl_s);
    assign complete_ok_s = complete_i & ~empty_s & (complete_id_i == IdWidth'(top_entry_s.id));

    // Next-state and handshake decode.
    always_comb begin
        next_state_s = state_r;
        load_offer_s = 1'b0;
        push_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (offer_ok_s) begin
                    load_offer_s = 1'b1;
                    next_state_s = OFFER;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OFFER: begin
                if (irq_ready_i) begin
                    push_s       = 1'b1;
                    next_state_s = SETTLE;
                end else begin
                    next_state_s = OFFER;
                end
            end
            SETTLE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Sequencer state, held offer, claim pulse and sticky protocol error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            offer_id_r  <= {IdWidth{1'b0}};
            offer_dl_r  <= {TsWidth{1'b0}};
            irq_valid_r <= 1'b0;
            claim_r     <= {NrIrqs{1'b0}};
            err_r       <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            irq_valid_r <= (next_state_s == OFFER);
            if (load_offer_s) begin
                offer_id_r <= arb_id_i;
                offer_dl_r <= arb_dl_i;
            end
            claim_r <= push_s ? (NrIrqs'(1) << offer_id_r) : {NrIrqs{1'b0}};
            if (complete_i && !complete_ok_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign irq_valid_o = irq_valid_r;
    assign irq_id_o    = offer_id_r;
    assign claim_o     = claim_r;
    assign err_o       = err_r;
    assign active_dl_o = active_dl_s;
    assign level_o     = depth_s;

`ifdef EDF_SEQ_DL_MISS_EN
    logic miss_r;
    logic miss_hit_s;

    assign miss_hit_s = ~empty_s & (mtime_i[TsWidth-1:0] >= active_dl_s);

    // Sticky miss flag; a fresh miss beats a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_r <= 1'b0;
        end else if (miss_hit_s) begin
            miss_r <= 1'b1;
        end else if (miss_clr_i) begin
            miss_r <= 1'b0;
        end
    end

    assign miss_o = miss_r;
`else
    logic unused_miss_s;

    assign unused_miss_s = ^{mtime_i, miss_clr_i};
    assign miss_o        = 1'b0;
`endif

endmodule

// File: tb/tb_edf_irq_sequencer.sv
// Directed self-checking bench for edf_irq_sequencer (built with NestDepth=2).
module tb_edf_irq_sequencer;

    localparam int unsigned NR = 4;
    localparam int unsigned TS = 64;
    localparam int unsigned ND = 2;
    localparam logic [63:0] ONES = {64{1'b1}};
`ifdef EDF_SEQ_DL_MISS_EN
    localparam logic [63:0] MISS_EN = 64'd1;
`else
    localparam logic [63:0] MISS_EN = 64'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arb_valid;
    logic [1:0]    arb_id;
    logic [TS-1:0] arb_dl;
    logic          irq_valid;
    logic [1:0]    irq_id;
    logic          irq_ready;
    logic          complete;
    logic [1:0]    complete_id;
    logic [NR-1:0] claim;
    logic [TS-1:0] active_dl;
    logic [1:0]    level;
    logic          err;
    logic [63:0]   mtime;
    logic          miss;
    logic          miss_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    edf_irq_sequencer #(
        .NrIrqs    (NR),
        .TsWidth   (TS),
        .NestDepth (ND)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .arb_valid_i   (arb_valid),
        .arb_id_i      (arb_id),
        .arb_dl_i      (arb_dl),
        .irq_valid_o   (irq_valid),
        .irq_id_o      (irq_id),
        .irq_ready_i   (irq_ready),
        .complete_i    (complete),
        .complete_id_i (complete_id),
        .claim_o       (claim),
        .active_dl_o   (active_dl),
        .level_o       (level),
        .err_o         (err),
        .mtime_i       (mtime),
        .miss_o        (miss),
        .miss_clr_i    (miss_clr)
    );

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        arb_valid   = 1'b0;
        arb_id      = 2'd0;
        arb_dl      = 64'd0;
        irq_ready   = 1'b0;
        complete    = 1'b0;
        complete_id = 2'd0;
        mtime       = 64'd0;
        miss_clr    = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic set_arb(input logic v, input logic [1:0] id, input logic [63:0] dl);
        arb_valid = v;
        arb_id    = id;
        arb_dl    = dl;
    endtask

    initial begin
        do_reset();
        chk_val("rst_valid", 64'(irq_valid), 64'd0);
        chk_val("rst_id", 64'(irq_id), 64'd0);
        chk_val("rst_claim", 64'(claim), 64'd0);
        chk_val("rst_level", 64'(level), 64'd0);
        chk_val("rst_err", 64'(err), 64'd0);
        chk_val("rst_miss", 64'(miss), 64'd0);
        chk_val("rst_active", active_dl, ONES);

        // Basic claim
        set_arb(1'b1, 2'd2, 64'd100);
        tick(1);
        chk_val("basic_valid", 64'(irq_valid), 64'd1);
        chk_val("basic_id", 64'(irq_id), 64'd2);
        set_arb(1'b0, 2'd0, 64'd0);
        irq_ready = 1'b1;
        tick(1);
        irq_ready = 1'b0;
        chk_val("basic_claim", 64'(claim), 64'h4);
        chk_val("basic_level", 64'(level), 64'd1);
        chk_val("basic_active", active_dl, 64'd100);
        chk_val("basic_settle", 64'(irq_valid), 64'd0);
        tick(1);
        chk_val("basic_claim_end", 64'(claim), 64'd0);

        // Preemption, offer held stable, equal deadline never preempts
        set_arb(1'b1, 2'd1, 64'd50);
        tick(1);
        chk_val("pre_valid", 64'(irq_valid), 64'd1);
        chk_val("pre_id", 64'(irq_id), 64'd1);
        set_arb(1'b1, 2'd3, 64'd100);
        tick(1);
        chk_val("pre_hold_id", 64'(irq_id), 64'd1);
        irq_ready = 1'b1;
        tick(1);
        irq_ready = 1'b0;
        chk_val("pre_claim", 64'(claim), 64'h2);
        chk_val("pre_level", 64'(level), 64'd2);
        chk_val("pre_active", active_dl, 64'd50);
        complete    = 1'b1;
        complete_id = 2'd1;
        tick(1);
        complete = 1'b0;
        chk_val("pre_pop_level", 64'(level), 64'd1);
        chk_val("pre_pop_active", active_dl, 64'd100);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_val("equal_no_offer", 64'(irq_valid), 64'd0);
        end

        // Full stack, bad completion, offer after pop
        set_arb(1'b1, 2'd0, 64'd50);
        tick(1);
        chk_val("full_offer_id", 64'(irq_id), 64'd0);
        irq_ready = 1'b1;
        tick(1);
        irq_ready = 1'b0;
        chk_val("full_claim", 64'(claim), 64'h1);
        chk_val("full_level", 64'(level), 64'd2);
        set_arb(1'b1, 2'd3, 64'd10);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_val("full_no_offer", 64'(irq_valid), 64'd0);
        end
        complete    = 1'b1;
        complete_id = 2'd3;
        tick(1);
        chk_val("bad_id_err", 64'(err), 64'd1);
        chk_val("bad_id_level", 64'(level), 64'd2);
        complete_id = 2'd0;
        tick(1);
        complete = 1'b0;
        chk_val("full_pop_level", 64'(level), 64'd1);
        chk_val("full_pop_active", active_dl, 64'd100);
        tick(1);
        chk_val("full_reoffer_valid", 64'(irq_valid), 64'd1);
        chk_val("full_reoffer_id", 64'(irq_id), 64'd3);
        irq_ready = 1'b1;
        tick(1);
        irq_ready = 1'b0;
        set_arb(1'b0, 2'd0, 64'd0);
        chk_val("full_reclaim", 64'(claim), 64'h8);
        chk_val("full_reactive", active_dl, 64'd10);
        complete    = 1'b1;
        complete_id = 2'd3;
        tick(1);
        complete_id = 2'd2;
        tick(1);
        complete = 1'b0;
        chk_val("drain_level", 64'(level), 64'd0);
        chk_val("drain_active", active_dl, ONES);

        // All-ones deadline on empty stack; completion on empty stack
        do_reset();
        chk_val("rst2_err", 64'(err), 64'd0);
        set_arb(1'b1, 2'd1, ONES);
        tick(2);
        chk_val("ones_no_offer", 64'(irq_valid), 64'd0);
        set_arb(1'b0, 2'd0, 64'd0);
        complete    = 1'b1;
        complete_id = 2'd0;
        tick(1);
        complete = 1'b0;
        chk_val("empty_cpl_err", 64'(err), 64'd1);
        chk_val("empty_cpl_level", 64'(level), 64'd0);

        // Simultaneous claim and complete, then reset mid-offer
        do_reset();
        set_arb(1'b1, 2'd2, 64'd100);
        tick(1);
        irq_ready = 1'b1;
        tick(1);
        irq_ready = 1'b0;
        set_arb(1'b1, 2'd1, 64'd40);
        tick(2);
        chk_val("sim_offer_id", 64'(irq_id), 64'd1);
        irq_ready   = 1'b1;
        complete    = 1'b1;
        complete_id = 2'd2;
        tick(1);
        irq_ready = 1'b0;
        complete  = 1'b0;
        chk_val("sim_level", 64'(level), 64'd1);
        chk_val("sim_active", active_dl, 64'd40);
        chk_val("sim_claim", 64'(claim), 64'h2);
        chk_val("sim_err", 64'(err), 64'd0);
        set_arb(1'b1, 2'd0, 64'd20);
        tick(2);
        chk_val("sim2_offer_id", 64'(irq_id), 64'd0);
        complete    = 1'b1;
        complete_id = 2'd1;
        tick(1);
        complete = 1'b0;
        chk_val("sim_top_pop_err", 64'(err), 64'd0);
        chk_val("sim_top_pop_level", 64'(level), 64'd0);
        chk_val("offer_no_withdraw", 64'(irq_valid), 64'd1);
        irq_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk_val("arst_valid", 64'(irq_valid), 64'd0);
        chk_val("arst_id", 64'(irq_id), 64'd0);
        chk_val("arst_claim", 64'(claim), 64'd0);
        chk_val("arst_active", active_dl, ONES);
        tick(1);
        chk_val("arst_claim_edge", 64'(claim), 64'd0);
        chk_val("arst_level", 64'(level), 64'd0);

        // Deadline miss
        do_reset();
        set_arb(1'b1, 2'd2, 64'd200);
        tick(1);
        irq_ready = 1'b1;
        tick(1);
        irq_ready = 1'b0;
        set_arb(1'b0, 2'd0, 64'd0);
        mtime = 64'd199;
        tick(1);
        chk_val("miss_199", 64'(miss), 64'd0);
        mtime = 64'd200;
        tick(1);
        chk_val("miss_200", 64'(miss), MISS_EN);
        mtime    = 64'd201;
        miss_clr = 1'b1;
        tick(1);
        miss_clr = 1'b0;
        chk_val("miss_clr_loses", 64'(miss), MISS_EN);
        complete    = 1'b1;
        complete_id = 2'd2;
        tick(1);
        complete = 1'b0;
        chk_val("miss_pop_level", 64'(level), 64'd0);
        chk_val("miss_pop", 64'(miss), MISS_EN);
        miss_clr = 1'b1;
        tick(1);
        miss_clr = 1'b0;
        chk_val("miss_cleared", 64'(miss), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
